// File: rtl/voice_alloc_pkg.sv
// Shared types and defaults for the voice allocator.
package voice_alloc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      LOAD  = 2'd2,
      WAIT  = 2'd3
   } alloc_state_e;

   localparam int NOTE_W_DEF = 6;
   localparam int DUR_W_DEF  = 6;

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin picker: first set bit of free at or after rr_ptr, wrapping.
module rr_free_picker #(
   parameter int N  = 3,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  free,
   input  logic [PW-1:0] rr_ptr,
   output logic          hit,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   int j;

   always_comb begin
      hit       = 1'b0;
      grant     = '0;
      grant_idx = '0;
      j         = 0;
      // Walk offsets from farthest to nearest so the nearest free voice is the last writer.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= N) j = j - N;
         if (free[j]) begin
            hit       = 1'b1;
            grant     = '0;
            grant[j]  = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Assigns (note, duration) requests to free note_player voices round-robin with a one-cycle load pulse.
// Optional VOICE_STEAL_EN: reload the least-recently-loaded voice instead of stalling; adds steal_count.
module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int NOTE_W     = NOTE_W_DEF,
   parameter int DUR_W      = DUR_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play,
   input  logic                  req_valid,
   input  logic [NOTE_W-1:0]     req_note,
   input  logic [DUR_W-1:0]      req_duration,
   output logic                  req_ready,
   input  logic [NUM_VOICES-1:0] voice_done,
   output logic [NUM_VOICES-1:0] load_note,
   output logic [NOTE_W-1:0]     note_out,
   output logic [DUR_W-1:0]      duration_out,
   output logic [NUM_VOICES-1:0] voice_busy,
`ifdef VOICE_STEAL_EN
   output logic [7:0]            steal_count,
`endif
   output logic                  all_idle
);

   localparam int PW = $clog2(NUM_VOICES);

   alloc_state_e          state_q, state_d;
   logic [NUM_VOICES-1:0] busy_q, busy_d;
   logic [NUM_VOICES-1:0] load_q, load_d;
   logic [NOTE_W-1:0]     hold_note_q, hold_note_d, note_q, note_d;
   logic [DUR_W-1:0]      hold_dur_q, hold_dur_d, dur_q, dur_d;
   logic [PW-1:0]         rr_q, rr_d;
   logic [NUM_VOICES-1:0] set_mask;

   logic                  hit;
   logic [NUM_VOICES-1:0] grant;
   logic [PW-1:0]         grant_idx;
   logic [NUM_VOICES-1:0] free;

   assign free = ~busy_q | voice_done;

   rr_free_picker #(.N(NUM_VOICES), .PW(PW)) u_picker (
      .free      (free),
      .rr_ptr    (rr_q),
      .hit       (hit),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

`ifdef VOICE_STEAL_EN
   logic [NUM_VOICES-1:0][PW-1:0] age_q, age_d;
   logic [7:0]                    steal_q, steal_d;
   logic [PW-1:0]                 oldest_idx, sel_idx;
   logic [NUM_VOICES-1:0]         oldest_mask;

   // Ages form a permutation of 0..NUM_VOICES-1; the maximum marks the least recently loaded voice.
   always_comb begin
      oldest_idx = '0;
      for (int v = 0; v < NUM_VOICES; v++)
         if (age_q[v] == PW'(NUM_VOICES - 1)) oldest_idx = PW'(v);
      oldest_mask = NUM_VOICES'(1) << oldest_idx;
   end
`endif

   always_comb begin
      state_d     = state_q;
      load_d      = '0;
      note_d      = note_q;
      dur_d       = dur_q;
      hold_note_d = hold_note_q;
      hold_dur_d  = hold_dur_q;
      rr_d        = rr_q;
      set_mask    = '0;
`ifdef VOICE_STEAL_EN
      steal_d     = steal_q;
      sel_idx     = grant_idx;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid && play && req_duration != '0) begin
               hold_note_d = req_note;
               hold_dur_d  = req_duration;
               state_d     = ALLOC;
            end
         end
         ALLOC, WAIT: begin
            if (play) begin
               if (hit) begin
                  load_d   = grant;
                  set_mask = grant;
                  note_d   = hold_note_q;
                  dur_d    = hold_dur_q;
                  rr_d     = (grant_idx == PW'(NUM_VOICES - 1)) ? '0 : grant_idx + 1'b1;
                  state_d  = LOAD;
               end else begin
`ifdef VOICE_STEAL_EN
                  load_d   = oldest_mask;
                  set_mask = oldest_mask;
                  sel_idx  = oldest_idx;
                  note_d   = hold_note_q;
                  dur_d    = hold_dur_q;
                  if (steal_q != 8'hff) steal_d = steal_q + 8'd1;
                  state_d  = LOAD;
`else
                  state_d  = WAIT;
`endif
               end
            end
         end
         LOAD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A load on a voice finishing this cycle keeps it busy.
      busy_d = (busy_q & ~voice_done) | set_mask;
   end

`ifdef VOICE_STEAL_EN
   always_comb begin
      age_d = age_q;
      if (|set_mask) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (set_mask[v]) age_d[v] = '0;
            else if (age_q[v] < age_q[sel_idx]) age_d[v] = age_q[v] + 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= '0;
         load_q      <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         hold_note_q <= '0;
         hold_dur_q  <= '0;
         rr_q        <= '0;
`ifdef VOICE_STEAL_EN
         steal_q     <= '0;
         for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= PW'(NUM_VOICES - 1 - i);
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         load_q      <= load_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         hold_note_q <= hold_note_d;
         hold_dur_q  <= hold_dur_d;
         rr_q        <= rr_d;
`ifdef VOICE_STEAL_EN
         steal_q     <= steal_d;
         age_q       <= age_d;
`endif
      end
   end

   assign req_ready    = (state_q == IDLE) && play;
   assign all_idle     = (busy_q == '0) && (state_q == IDLE);
   assign load_note    = load_q;
   assign note_out     = note_q;
   assign duration_out = dur_q;
   assign voice_busy   = busy_q;
`ifdef VOICE_STEAL_EN
   assign steal_count  = steal_q;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_voice_allocator;

   localparam int NV = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          play = 1'b0;
   logic          req_valid = 1'b0;
   logic [5:0]    req_note = '0;
   logic [5:0]    req_duration = '0;
   logic          req_ready;
   logic [NV-1:0] voice_done = '0;
   logic [NV-1:0] load_note;
   logic [5:0]    note_out;
   logic [5:0]    duration_out;
   logic [NV-1:0] voice_busy;
   logic          all_idle;
`ifdef VOICE_STEAL_EN
   logic [7:0]    steal_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   voice_allocator #(.NUM_VOICES(NV), .NOTE_W(6), .DUR_W(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .play         (play),
      .req_valid    (req_valid),
      .req_note     (req_note),
      .req_duration (req_duration),
      .req_ready    (req_ready),
      .voice_done   (voice_done),
      .load_note    (load_note),
      .note_out     (note_out),
      .duration_out (duration_out),
      .voice_busy   (voice_busy),
`ifdef VOICE_STEAL_EN
      .steal_count  (steal_count),
`endif
      .all_idle     (all_idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a request is either pending a voice, or its pulse is showing, or nothing is in flight.
   logic          m_pend, m_pulse;
   int            m_lv, m_rr, m_cnt, m_now;
   logic [5:0]    m_hnote, m_hdur, m_lnote, m_ldur;
   logic [NV-1:0] m_busy, m_nb;
   int            m_time [NV];
   int            m_sel;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pend = 0; m_pulse = 0; m_rr = 0; m_busy = '0; m_cnt = 0; m_now = 0; m_lv = 0;
         for (int i = 0; i < NV; i++) m_time[i] = i - NV;
      end else begin
         m_now++;
         m_sel = -1;
         m_nb  = m_busy & ~voice_done;
         if (m_pulse) m_pulse = 0;
         else if (m_pend) begin
            if (play) begin
               for (int k = 0; k < NV; k++)
                  if (m_sel < 0 && (!m_busy[(m_rr + k) % NV] || voice_done[(m_rr + k) % NV]))
                     m_sel = (m_rr + k) % NV;
               if (m_sel >= 0) m_rr = (m_sel + 1) % NV;
`ifdef VOICE_STEAL_EN
               else begin
                  m_sel = 0;
                  for (int v = 1; v < NV; v++) if (m_time[v] < m_time[m_sel]) m_sel = v;
                  if (m_cnt < 255) m_cnt++;
               end
`endif
               if (m_sel >= 0) begin
                  m_pulse = 1; m_pend = 0; m_lv = m_sel;
                  m_nb[m_sel] = 1'b1; m_time[m_sel] = m_now;
                  m_lnote = m_hnote; m_ldur = m_hdur;
               end
            end
         end else if (req_valid && play && req_duration != 0) begin
            m_pend = 1; m_hnote = req_note; m_hdur = req_duration;
         end
         m_busy = m_nb;
      end
   end

   always @(negedge clk) begin
      chk("req_ready", req_ready, play && !m_pend && !m_pulse);
      chk("load_note", load_note, m_pulse ? (NV'(1) << m_lv) : '0);
      chk("voice_busy", voice_busy, m_busy);
      chk("all_idle", all_idle, (m_busy == 0) && !m_pend && !m_pulse);
      if (m_pulse) begin
         chk("note_out", note_out, m_lnote);
         chk("duration_out", duration_out, m_ldur);
      end
`ifdef VOICE_STEAL_EN
      chk("steal_count", steal_count, m_cnt);
`endif
   end

   task automatic send(input logic [5:0] n, input logic [5:0] d);
      int w;
      w = 0;
      req_valid = 1'b1; req_note = n; req_duration = d;
      @(negedge clk);
      while (!req_ready && w < 50) begin @(negedge clk); w++; end
      if (!req_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: req_ready stuck at 0, required 1");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic send_chk(input logic [5:0] n, input logic [NV-1:0] exp);
      send(n, 6'd4);
      @(negedge clk); chk("lat_n1_load", load_note, '0);
      @(negedge clk); chk("lat_n2_load", load_note, exp);
      chk("lat_n2_note", note_out, n);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_load", load_note, '0);
      chk("rst_busy", voice_busy, '0);
      chk("rst_idle", all_idle, 1'b1);
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_note", note_out, '0);
      chk("rst_dur", duration_out, '0);
      @(posedge clk); #1; reset = 1'b0; play = 1'b1;

      send_chk(6'd10, 3'b001);
      send_chk(6'd20, 3'b010);
      send_chk(6'd30, 3'b100);
      chk("busy_all", voice_busy, 3'b111);

`ifdef VOICE_STEAL_EN
      send_chk(6'd40, 3'b001);
      chk("steal_cnt1", steal_count, 8'd1);
      chk("steal_busy", voice_busy, 3'b111);
`else
      // All busy: request 40 waits until voice 1 finishes.
      send(6'd40, 6'd4);
      @(negedge clk); chk("wait_load_a", load_note, '0);
      @(negedge clk); chk("wait_load_b", load_note, '0);
      chk("wait_ready", req_ready, 1'b0);
      chk("wait_idle", all_idle, 1'b0);
      voice_done = 3'b010;
      @(posedge clk); #1; voice_done = '0;
      @(negedge clk); chk("wait_rel_load", load_note, 3'b010);
      chk("wait_rel_note", note_out, 6'd40);
      chk("wait_rel_busy", voice_busy, 3'b111);

      // Done and load on voice 0 in the same cycle: set wins.
      send(6'd50, 6'd4);
      voice_done = 3'b001;
      @(negedge clk); chk("sameclk_n1", load_note, '0);
      @(posedge clk); #1; voice_done = '0;
      @(negedge clk); chk("sameclk_load", load_note, 3'b001);
      chk("sameclk_busy", voice_busy, 3'b111);

      // Zero duration is swallowed.
      send(6'd60, 6'd0);
      @(negedge clk); chk("dur0_load", load_note, '0);
      chk("dur0_ready", req_ready, 1'b1);
      chk("dur0_busy", voice_busy, 3'b111);

      // Pause while allocating with a free voice.
      @(posedge clk); #1; voice_done = 3'b100;
      @(posedge clk); #1; voice_done = '0;
      send(6'd7, 6'd9);
      play = 1'b0;
      @(negedge clk); chk("pause_n1", load_note, '0);
      @(posedge clk); #1; play = 1'b1;
      @(negedge clk); chk("pause_n2", load_note, '0);
      @(negedge clk); chk("pause_load", load_note, 3'b100);
      chk("pause_dur", duration_out, 6'd9);

      // Reset in WAIT returns everything at once.
      send(6'd33, 6'd4);
      @(negedge clk); @(negedge clk);
      chk("prewait_ready", req_ready, 1'b0);
      #2; play = 1'b0; reset = 1'b1;
      #1;
      chk("midrst_load", load_note, '0);
      chk("midrst_busy", voice_busy, '0);
      chk("midrst_idle", all_idle, 1'b1);
      chk("midrst_ready", req_ready, 1'b0);
      @(posedge clk); #1; reset = 1'b0; play = 1'b1;
`endif

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         reset        = (c == 1500);
         play         = ($urandom_range(0, 9) != 0);
         req_valid    = ($urandom_range(0, 2) != 0);
         req_note     = 6'($urandom_range(0, 63));
         req_duration = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         for (int v = 0; v < NV; v++) voice_done[v] = ($urandom_range(0, 5) == 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; voice_done = '0; reset = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Scheduler between the song reader and the bank of note_player voices. Chord notes arrive as a stream of (note, duration) requests.
- Each accepted request is assigned to a free voice, round-robin, and that voice gets a one-cycle load pulse.
- Busy state is tracked per voice from done_with_note pulses. Requests stall while every voice is busy.
- The mixer and codec_conditioner path is untouched; this block only sequences note loading.

Parameters:
- NUM_VOICES, 3, number of note_player instances served (2..8).
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width in beats.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset. Single clock domain; all state resets on reset assertion.
- play, input, 1, MCU play enable; 0 pauses allocation.
- req_valid, input, 1, request present.
- req_note, input, NOTE_W, note code; 0 = rest.
- req_duration, input, DUR_W, duration in beats.
- req_ready, output, 1, block can accept a request this cycle.
- voice_done, input, NUM_VOICES, per-voice done_with_note pulses.
- load_note, output, NUM_VOICES, one-hot load pulse to the selected voice.
- note_out, output, NOTE_W, note for the loaded voice; valid while load_note != 0.
- duration_out, output, DUR_W, duration for the loaded voice; valid while load_note != 0.
- voice_busy, output, NUM_VOICES, per-voice busy flags.
- all_idle, output, 1, high when voice_busy == 0 and FSM is in IDLE.

Behaviour:
- Reset values: FSM=IDLE, load_note=0, note_out=0, duration_out=0, voice_busy=0, rr_ptr=0, req_ready=0, all_idle=1.
- States: IDLE, ALLOC, LOAD, WAIT.
- IDLE:
  - req_ready = play (combinational from state and play).
  - On req_valid && req_ready: capture note and duration into holding registers, go to ALLOC.
  - A request with req_duration == 0 is accepted and discarded; FSM stays in IDLE, no load.
- ALLOC:
  - free = ~voice_busy | voice_done. A voice finishing this cycle counts as free.
  - Search free from rr_ptr upward, wrapping modulo NUM_VOICES.
  - Hit at voice i: register load_note = 1<<i, note_out and duration_out from the holding registers, set voice_busy[i], set rr_ptr = (i+1) mod NUM_VOICES, go to LOAD.
  - No free voice: go to WAIT.
  - If play = 0: remain in ALLOC; no load is issued.
- LOAD: load_note is high for exactly this one cycle, then cleared; go to IDLE.
- WAIT: re-run the ALLOC search every cycle play = 1; on the first hit, behave exactly as ALLOC.
- Latency: request accepted at cycle N; load_note high at N+2 when a voice is free.
- Busy tracking:
  - voice_done[i] clears voice_busy[i].
  - If set and clear target the same voice in the same cycle, set wins (new note loaded).
  - voice_done on an already-idle voice is ignored.
  - Multiple simultaneous voice_done bits are all honoured.
- Throughput: at most one request every 3 cycles (IDLE, ALLOC, LOAD).
- A rest (note 0) with nonzero duration occupies a voice like any other note.
- Reset mid-operation (any state): asynchronous return to reset values. The holding request is lost; no partial load pulse.
- play falling during LOAD: the pulse still completes.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined:
  - Each voice keeps a log2(NUM_VOICES)-bit LRU age, updated on every load.
  - When ALLOC finds no free voice, the oldest-loaded voice is reloaded immediately. It stays busy; load_note pulses for it.
  - rr_ptr is left unchanged on a steal.
  - WAIT state is unreachable.
  - Adds output steal_count[7:0]: increments per steal, saturates at 255, resets to 0.
- Undefined: the WAIT stall behaviour above; no age logic and no steal_count port.

Decomposition:
- Package voice_alloc_pkg holds:
  - state encoding constants IDLE=2'd0, ALLOC=2'd1, LOAD=2'd2, WAIT=2'd3;
  - default NOTE_W and DUR_W.
- One sub-module, rr_free_picker: combinational round-robin priority picker.
  - Inputs: free mask, rr_ptr.
  - Outputs: hit, one-hot grant, grant index.
- The FSM, busy registers and age logic stay in voice_allocator.

Test Plan:
- Reset, play=1, three requests (notes 10, 20, 30; dur 4) sent back-to-back → load_note 001, 010, 100 in that order. Each pulse lands 2 cycles after its accept; voice_busy=111.
- All busy, fourth request (note 40) → req_ready low after accept, FSM in WAIT, no pulse. Then voice_done=010 → load_note=010 with note_out=40 on the next cycle; voice_busy stays 111.
- voice_done=001 in the same cycle ALLOC targets voice 0 → voice 0 reloaded, voice_busy[0] stays 1.
- req_duration=0 → accepted, no load_note, voice_busy unchanged.
- play=0 while in ALLOC with a free voice → no load; play=1 → load pulse 1 cycle later. Reset asserted mid-WAIT → all outputs return to reset values immediately.
- VOICE_STEAL_EN, all busy, fourth request → load_note=001 (oldest voice), steal_count=1.
